// File: rtl/otg_hpi_bus_sequencer_pkg.sv
// otg_hpi_pkg: shared types and constants for the OTG HPI bus sequencer.
//   state_e    - sequencer FSM states
//   HPI_*      - HPI register select codes driven on otg_addr
//   CNT_W      - width of the shared phase down-counter
//   cnt_load() - counter load value for a phase of n cycles
package otg_hpi_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, DONE, RECOVER
  } state_e;

  // Phases run until the counter reads zero, so an n-cycle phase loads n-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/otg_hpi_bus_sequencer_if.sv
// otg_hpi_bus_sequencer_if: Avalon-MM slave signals plus the CY7C67200 HPI pins.
//   slave  - sequencer view (Avalon inputs, HPI pin outputs, otg_data_in input)
//   master - fabric / board view (the mirror image)
interface otg_hpi_bus_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [1:0]  otg_addr;
  logic        otg_cs_n;
  logic        otg_rd_n;
  logic        otg_wr_n;
  logic [15:0] otg_data_out;
  logic        otg_data_oe;
  logic [15:0] otg_data_in;

  modport slave (
    input  address, chipselect, read_n, write_n, writedata, otg_data_in,
    output readdata, waitrequest, otg_addr, otg_cs_n, otg_rd_n, otg_wr_n,
           otg_data_out, otg_data_oe
  );

  modport master (
    output address, chipselect, read_n, write_n, writedata, otg_data_in,
    input  readdata, waitrequest, otg_addr, otg_cs_n, otg_rd_n, otg_wr_n,
           otg_data_out, otg_data_oe
  );
endinterface

// File: rtl/otg_hpi_bus_sequencer_int_sync.sv
// otg_hpi_int_sync: two-flop synchronizer for the asynchronous OTG INT pin.
//   clk, reset_n - system clock, async active-low reset
//   d            - asynchronous input level
//   q            - synchronized level, two cycles of latency, resets to 0
module otg_hpi_int_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/otg_hpi_bus_sequencer.sv
// otg_hpi_bus_sequencer: turns each Avalon-MM access into one timed HPI cycle
// (setup, strobe, hold, done, recover) on the CY7C67200 host port.
//   clk, reset_n   - system clock, async active-low reset (releases the bus at once)
//   bus (slave)    - Avalon address/chipselect/read_n/write_n/writedata/readdata/
//                    waitrequest and HPI otg_addr/cs_n/rd_n/wr_n/data_out/data_oe/data_in
//   otg_int, irq   - only with OTG_HPI_IRQ_EN: raw INT pin and its synchronized level
// Build option: define OTG_HPI_IRQ_EN to add the INT synchronizer, the irq output and
// the INT level in readdata[16] of STATUS reads.
module otg_hpi_bus_sequencer
  import otg_hpi_pkg::*;
#(
  parameter int SETUP_CYC   = 1,
  parameter int PULSE_CYC   = 3,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 2
) (
  input  logic clk,
  input  logic reset_n,
`ifdef OTG_HPI_IRQ_EN
  input  logic otg_int,
  output logic irq,
`endif
  otg_hpi_bus_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_wr_q, is_wr_d;
  logic [1:0]       addr_q, addr_d;
  logic [15:0]      dout_q, dout_d;
  logic             cs_n_q, cs_n_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_n_q, wr_n_d;
  logic             oe_q, oe_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             rd_hi_q, rd_hi_d;
  logic             req, last, int_lvl;
  logic             unused_wdata_hi;

`ifdef OTG_HPI_IRQ_EN
  otg_hpi_int_sync u_int_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (otg_int),
    .q       (int_lvl)
  );
  assign irq = int_lvl;
`else
  assign int_lvl = 1'b0;
`endif

  assign req  = bus.chipselect && (!bus.read_n || !bus.write_n);
  assign last = (cnt_q == '0);
  assign unused_wdata_hi = ^bus.writedata[31:16];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    cs_n_d  = cs_n_q;
    rd_n_d  = rd_n_q;
    wr_n_d  = wr_n_q;
    oe_d    = oe_q;
    rdata_d = rdata_q;
    rd_hi_d = rd_hi_q;
    unique case (state_q)
      IDLE: if (req) begin
        state_d = SETUP;
        cnt_d   = cnt_load(SETUP_CYC);
        addr_d  = bus.address;
        is_wr_d = !bus.write_n;           // write wins when both strobes are low
        cs_n_d  = 1'b0;
        if (!bus.write_n) begin
          dout_d = bus.writedata[15:0];
          oe_d   = 1'b1;
        end
      end
      SETUP: begin
        cnt_d = cnt_q - 1'b1;
        if (last) begin
          state_d = STROBE;
          cnt_d   = cnt_load(PULSE_CYC);
          rd_n_d  = is_wr_q;
          wr_n_d  = !is_wr_q;
        end
      end
      STROBE: begin
        cnt_d = cnt_q - 1'b1;
        if (last) begin
          rd_n_d = 1'b1;
          wr_n_d = 1'b1;
          // An abandoned read (req dropped) still runs the bus cycle but keeps readdata.
          if (!is_wr_q && req) begin
            rdata_d = bus.otg_data_in;
            rd_hi_d = (addr_q == HPI_STATUS) && int_lvl;
          end
          if (HOLD_CYC == 0) begin
            // No hold phase: CS_N stays low through DONE so it never rises with the strobe.
            state_d = DONE;
            oe_d    = 1'b0;
          end else begin
            state_d = HOLD;
            cnt_d   = cnt_load(HOLD_CYC);
          end
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (last) begin
          state_d = DONE;
          cs_n_d  = 1'b1;
          oe_d    = 1'b0;
        end
      end
      DONE: begin
        cs_n_d = 1'b1;
        if (RECOVER_CYC == 0) begin
          state_d = IDLE;
        end else begin
          state_d = RECOVER;
          cnt_d   = cnt_load(RECOVER_CYC);
        end
      end
      RECOVER: begin
        cnt_d = cnt_q - 1'b1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      rdata_q <= '0;
      rd_hi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      oe_q    <= oe_d;
      rdata_q <= rdata_d;
      rd_hi_q <= rd_hi_d;
    end
  end

  assign bus.waitrequest  = req && (state_q != DONE);
  assign bus.readdata     = {15'd0, rd_hi_q, rdata_q};
  assign bus.otg_addr     = addr_q;
  assign bus.otg_cs_n     = cs_n_q;
  assign bus.otg_rd_n     = rd_n_q;
  assign bus.otg_wr_n     = wr_n_q;
  assign bus.otg_data_out = dout_q;
  assign bus.otg_data_oe  = oe_q;

endmodule

// File: tb/tb_otg_hpi_bus_sequencer.sv
// Bench for otg_hpi_bus_sequencer: a default-timing instance (b0) and a
// SETUP=1/PULSE=1/HOLD=0 instance (b1), driven with random accesses and checked
// cycle by cycle against a timeline model of the HPI cycle.
module tb_otg_hpi_bus_sequencer;
  import otg_hpi_pkg::*;

  localparam int S0 = 1, P0 = 3, H0 = 1, R0 = 2;
  localparam int S1 = 1, P1 = 1, H1 = 0, R1 = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  otg_hpi_bus_sequencer_if b0 ();
  otg_hpi_bus_sequencer_if b1 ();
`ifdef OTG_HPI_IRQ_EN
  logic otg_int = 1'b0;
  logic irq0, irq1;
`endif

  otg_hpi_bus_sequencer #(.SETUP_CYC(S0), .PULSE_CYC(P0), .HOLD_CYC(H0), .RECOVER_CYC(R0)) dut (
    .clk (clk), .reset_n (reset_n),
`ifdef OTG_HPI_IRQ_EN
    .otg_int (otg_int), .irq (irq0),
`endif
    .bus (b0)
  );

  otg_hpi_bus_sequencer #(.SETUP_CYC(S1), .PULSE_CYC(P1), .HOLD_CYC(H1), .RECOVER_CYC(R1)) dut_h0 (
    .clk (clk), .reset_n (reset_n),
`ifdef OTG_HPI_IRQ_EN
    .otg_int (otg_int), .irq (irq1),
`endif
    .bus (b1)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_rd0 = '0, last_rd1 = '0;

  // Recorded timeline of one access: {cs_n, rd_n, wr_n, oe, waitrequest} per cycle.
  logic [4:0]  obs [0:63];
  logic [15:0] dout_obs [0:63];
  logic [31:0] rdata_at_done;
  int          lat;

  // Expected pins at cycle j after the access is accepted in IDLE (j=0).
  function automatic logic [4:0] exp_sig(input int j, input bit wr, input int s, input int p, input int h);
    int  l;
    bit  cs_low, stb, oe, wt;
    l      = 1 + s + p + h;
    cs_low = (j >= 1) && ((j <= s + p + h) || (h == 0 && j == l));
    stb    = (j >= s + 1) && (j <= s + p);
    oe     = wr && (j >= 1) && (j <= s + p + h);
    wt     = (j < l);
    return {~cs_low, ~(stb && !wr), ~(stb && wr), oe, wt};
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] a, input logic [15:0] chip, input bit lvl);
`ifdef OTG_HPI_IRQ_EN
    return {15'd0, lvl && (a == HPI_STATUS), chip};
`else
    return {16'd0, chip};
`endif
  endfunction

  task automatic drive_req(input bit sel, input bit req, input bit wr, input bit both,
                           input logic [1:0] a, input logic [31:0] d);
    logic rn, wn;
    rn = !(req && (!wr || both));
    wn = !(req && wr);
    if (!sel) begin
      b0.chipselect = req; b0.read_n = rn; b0.write_n = wn; b0.address = a; b0.writedata = d;
    end else begin
      b1.chipselect = req; b1.read_n = rn; b1.write_n = wn; b1.address = a; b1.writedata = d;
    end
  endtask

  task automatic set_din(input bit sel, input logic [15:0] v);
    if (!sel) b0.otg_data_in = v; else b1.otg_data_in = v;
  endtask

  function automatic logic [4:0] sample(input bit sel);
    if (!sel) return {b0.otg_cs_n, b0.otg_rd_n, b0.otg_wr_n, b0.otg_data_oe, b0.waitrequest};
    return {b1.otg_cs_n, b1.otg_rd_n, b1.otg_wr_n, b1.otg_data_oe, b1.waitrequest};
  endfunction

  // Assert a request, record pins each cycle until waitrequest falls (bounded),
  // drop the request and record one more cycle. The chip drives `chip` only in
  // the last strobe cycle (off+s+p); other cycles see random junk.
  task automatic run_access(input bit sel, input bit wr, input bit both, input logic [1:0] a,
                            input logic [31:0] d, input logic [15:0] chip, input int off,
                            input int s, input int p);
    int idx;
    lat = -1;
    drive_req(sel, 1'b1, wr, both, a, d);
    set_din(sel, 16'($urandom));
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      obs[k]      = sample(sel);
      dout_obs[k] = sel ? b1.otg_data_out : b0.otg_data_out;
      set_din(sel, (k == off + s + p) ? chip : 16'($urandom));
      if (obs[k][0] == 1'b0) begin
        lat = k;
        rdata_at_done = sel ? b1.readdata : b0.readdata;
      end
    end
    drive_req(sel, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    @(negedge clk);
    idx = (lat < 0) ? 41 : lat + 1;
    obs[idx]      = sample(sel);
    dout_obs[idx] = sel ? b1.otg_data_out : b0.otg_data_out;
  endtask

  task automatic test_reset();
    vectors++;
    if ({sample(0), b0.otg_addr, b0.otg_data_out, b0.readdata} !== {5'b11100, 2'd0, 16'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_b0: got pins=%b addr=%0d dout=%h rd=%h, want pins=11100 addr=0 dout=0 rd=0",
               sample(0), b0.otg_addr, b0.otg_data_out, b0.readdata);
    end
    vectors++;
    if ({sample(1), b1.otg_addr, b1.otg_data_out, b1.readdata} !== {5'b11100, 2'd0, 16'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_b1: got pins=%b addr=%0d dout=%h rd=%h, want pins=11100 addr=0 dout=0 rd=0",
               sample(1), b1.otg_addr, b1.otg_data_out, b1.readdata);
    end
  endtask

  task automatic test_write();
    logic [31:0] d;
    logic [1:0]  a;
    for (int n = 0; n < 5; n++) begin
      a = (n == 0) ? 2'd2 : 2'($urandom);
      d = (n == 0) ? 32'h0000_1234 : $urandom;
      run_access(0, 1, (n == 3), a, d, 16'($urandom), 0, S0, P0);
      vectors++;
      if (lat !== 1 + S0 + P0 + H0) begin
        miscompares++;
        $display("FAIL write_latency n=%0d: got %0d want %0d", n, lat, 1 + S0 + P0 + H0);
      end else begin
        for (int k = 1; k <= lat + 1; k++) begin
          vectors++;
          if (obs[k] !== exp_sig(k, 1, S0, P0, H0) ||
              (exp_sig(k, 1, S0, P0, H0)[1] && dout_obs[k] !== d[15:0])) begin
            miscompares++;
            $display("FAIL write_pins n=%0d cyc=%0d: got %b dout=%h want %b dout=%h",
                     n, k, obs[k], dout_obs[k], exp_sig(k, 1, S0, P0, H0), d[15:0]);
          end
        end
        vectors++;
        if (rdata_at_done !== last_rd0) begin
          miscompares++;
          $display("FAIL write_keeps_readdata n=%0d: got %h want %h", n, rdata_at_done, last_rd0);
        end
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_read();
    logic [15:0] chip;
    logic [1:0]  a;
    for (int n = 0; n < 5; n++) begin
      a    = (n == 0) ? 2'd0 : 2'($urandom);
      chip = (n == 0) ? 16'hBEEF : 16'($urandom);
      run_access(0, 0, 0, a, $urandom, chip, 0, S0, P0);
      vectors++;
      if (lat !== 1 + S0 + P0 + H0) begin
        miscompares++;
        $display("FAIL read_latency n=%0d: got %0d want %0d", n, lat, 1 + S0 + P0 + H0);
      end else begin
        for (int k = 1; k <= lat + 1; k++) begin
          vectors++;
          if (obs[k] !== exp_sig(k, 0, S0, P0, H0)) begin
            miscompares++;
            $display("FAIL read_pins n=%0d cyc=%0d: got %b want %b", n, k, obs[k], exp_sig(k, 0, S0, P0, H0));
          end
        end
        last_rd0 = exp_read(a, chip, 1'b0);
        vectors++;
        if (rdata_at_done !== last_rd0) begin
          miscompares++;
          $display("FAIL read_data n=%0d: got %h want %h", n, rdata_at_done, last_rd0);
        end
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int first_lat, fall_k;
    logic [31:0] d;
    fall_k = -1;
    run_access(0, 1, 0, 2'd1, $urandom, 16'h0, 0, S0, P0);
    first_lat = lat;
    d = $urandom;
    // Second request is raised right after DONE, while the sequencer is recovering.
    run_access(0, 1, 0, 2'd3, d, 16'h0, R0, S0, P0);
    vectors++;
    if (first_lat !== 1 + S0 + P0 + H0 || lat !== R0 + 1 + S0 + P0 + H0) begin
      miscompares++;
      $display("FAIL b2b_latency: got %0d/%0d want %0d/%0d", first_lat, lat,
               1 + S0 + P0 + H0, R0 + 1 + S0 + P0 + H0);
    end else begin
      for (int k = 1; k <= lat + 1; k++) begin
        vectors++;
        if (obs[k] !== exp_sig(k - R0, 1, S0, P0, H0)) begin
          miscompares++;
          $display("FAIL b2b_pins cyc=%0d: got %b want %b", k, obs[k], exp_sig(k - R0, 1, S0, P0, H0));
        end
        if (fall_k < 0 && obs[k][4] == 1'b0) fall_k = k;
        if (k > 1) begin
          vectors++;
          if ((obs[k][4] != obs[k-1][4]) && ((obs[k][3] & obs[k][2]) != (obs[k-1][3] & obs[k-1][2]))) begin
            miscompares++;
            $display("FAIL b2b_strobe_cs_same_edge cyc=%0d: got cs %b->%b stb %b->%b want no shared edge",
                     k, obs[k-1][4], obs[k][4], obs[k-1][3:2], obs[k][3:2]);
          end
        end
      end
      // Gap between first DONE and the second CS_N fall; must be at least 3.
      vectors++;
      if (fall_k + 1 !== R0 + 2) begin
        miscompares++;
        $display("FAIL b2b_gap: got %0d cycles want %0d", fall_k + 1, R0 + 2);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] chip;
    drive_req(0, 1, 1, 0, 2'd1, $urandom);
    repeat (S0 + 2) @(negedge clk);
    vectors++;
    if (b0.otg_wr_n !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_in_strobe: got wr_n=%b want 0", b0.otg_wr_n);
    end
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if ({b0.otg_cs_n, b0.otg_rd_n, b0.otg_wr_n, b0.otg_data_oe, b0.readdata} !== {4'b1110, 32'd0}) begin
      miscompares++;
      $display("FAIL rstmid_async: got cs/rd/wr/oe=%b rd=%h want 1110 rd=0",
               {b0.otg_cs_n, b0.otg_rd_n, b0.otg_wr_n, b0.otg_data_oe}, b0.readdata);
    end
    drive_req(0, 0, 0, 0, 2'd0, 32'd0);
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    last_rd0 = '0;
    last_rd1 = '0;
    repeat (2) @(negedge clk);
    chip = 16'($urandom);
    run_access(0, 0, 0, 2'd0, 32'd0, chip, 0, S0, P0);
    vectors++;
    if (lat !== 1 + S0 + P0 + H0 || rdata_at_done !== exp_read(2'd0, chip, 1'b0)) begin
      miscompares++;
      $display("FAIL rstmid_next_read: got lat=%0d rd=%h want lat=%0d rd=%h",
               lat, rdata_at_done, 1 + S0 + P0 + H0, exp_read(2'd0, chip, 1'b0));
    end
    last_rd0 = exp_read(2'd0, chip, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_hold0();
    logic [15:0] chip;
    bit wr;
    for (int n = 0; n < 4; n++) begin
      wr   = n[0];
      chip = 16'($urandom);
      run_access(1, wr, 0, 2'($urandom), $urandom, chip, 0, S1, P1);
      vectors++;
      if (lat !== 3) begin
        miscompares++;
        $display("FAIL hold0_latency n=%0d: got %0d want 3", n, lat);
      end else begin
        for (int k = 1; k <= lat + 1; k++) begin
          vectors++;
          if (obs[k] !== exp_sig(k, wr, S1, P1, H1)) begin
            miscompares++;
            $display("FAIL hold0_pins n=%0d cyc=%0d: got %b want %b", n, k, obs[k], exp_sig(k, wr, S1, P1, H1));
          end
        end
        if (!wr) last_rd1 = {16'd0, chip};
        vectors++;
        if (rdata_at_done !== last_rd1) begin
          miscompares++;
          $display("FAIL hold0_readdata n=%0d: got %h want %h", n, rdata_at_done, last_rd1);
        end
      end
      repeat (4) @(negedge clk);
    end
  endtask

`ifdef OTG_HPI_IRQ_EN
  task automatic test_irq();
    logic [15:0] chip;
    otg_int = 1'b1;
    @(negedge clk);
    vectors++;
    if (irq0 !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_early: got %b want 0", irq0);
    end
    @(negedge clk);
    vectors++;
    if (irq0 !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_rise: got %b want 1", irq0);
    end
    chip = 16'($urandom);
    run_access(0, 0, 0, HPI_STATUS, 32'd0, chip, 0, S0, P0);
    last_rd0 = exp_read(HPI_STATUS, chip, 1'b1);
    vectors++;
    if (rdata_at_done !== last_rd0) begin
      miscompares++;
      $display("FAIL irq_status_read: got %h want %h", rdata_at_done, last_rd0);
    end
    otg_int = 1'b0;
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin
    drive_req(0, 0, 0, 0, 2'd0, 32'd0);
    drive_req(1, 0, 0, 0, 2'd0, 32'd0);
    set_din(0, 16'd0);
    set_din(1, 16'd0);
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_hold0();
`ifdef OTG_HPI_IRQ_EN
    test_irq();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1);
  end

endmodule

// File: doc/otg_hpi_bus_sequencer.md
Name: otg_hpi_bus_sequencer

Overview:
- Hardware HPI transaction engine between the system Avalon-MM fabric and the CY7C67200 EZ-OTG Host Port Interface pins.
- Replaces software bit-banging of the separate data/address/cs/rd/wr PIOs.
- Sits directly downstream of the HPI data PIO path: it owns the 16-bit OTG data bus drivers and captures chip read data.
- Each Avalon access becomes one timed HPI cycle: setup, strobe, hold, then recovery.

Parameters:
- SETUP_CYC, 1, cycles with CS_N/address/data valid before the strobe; legal 1..15.
- PULSE_CYC, 3, cycles the RD_N/WR_N strobe is held low; legal 1..15.
- HOLD_CYC, 1, cycles with CS_N low after the strobe rises; legal 0..15 (0 skips HOLD).
- RECOVER_CYC, 2, idle cycles after DONE before the next access is accepted; legal 0..15.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; one clock, asynchronous, active-low
- address  in  2  HPI register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
- chipselect  in  1  Avalon slave select
- read_n  in  1  Avalon read, active-low
- write_n  in  1  Avalon write, active-low
- writedata  in  32  write data; bits 15:0 used
- readdata  out  32  captured HPI read data, zero-extended
- waitrequest  out  1  Avalon stall
- otg_addr  out  2  HPI address pins
- otg_cs_n  out  1  HPI chip select
- otg_rd_n  out  1  HPI read strobe
- otg_wr_n  out  1  HPI write strobe
- otg_data_out  out  16  value for the tristate data bus
- otg_data_oe  out  1  data bus output enable (1 = FPGA drives)
- otg_data_in  in  16  sampled data bus

Behaviour:
- req = chipselect && (~read_n || ~write_n).
- waitrequest = req && (state != DONE). It is combinational, so it is low for exactly one cycle per completed access.
- The master holds its request while waitrequest is high.
- States and transitions:
  - IDLE: on req, latch address, writedata[15:0] and direction; go to SETUP. If write_n and read_n are both low, the access is a write.
  - SETUP (SETUP_CYC cycles): otg_cs_n=0, otg_addr=latched address. For writes, otg_data_oe=1 and data is driven. otg_rd_n=otg_wr_n=1.
  - STROBE (PULSE_CYC cycles): otg_rd_n=0 (read) or otg_wr_n=0 (write). For reads, otg_data_in is sampled into readdata on the last STROBE cycle.
  - HOLD (HOLD_CYC cycles): strobes high; CS_N, address and write data are held.
  - DONE (1 cycle): otg_cs_n=1, otg_data_oe=0, waitrequest low.
  - RECOVER (RECOVER_CYC cycles): a new req is ignored (waitrequest high), then go to IDLE. If RECOVER_CYC=0, DONE goes straight to IDLE.
- Latency: waitrequest goes low 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles after req is first seen in IDLE.
- Counter: one down-counter, 4 bits, loaded with (N-1) on state entry.
- Outputs: all otg_* outputs are registered and glitch-free. Strobes never fall in the same cycle CS_N falls, and never rise in the same cycle CS_N rises.
- readdata: holds its value until the next read completes; writes do not alter it.
- If req is dropped mid-access (protocol violation), the HPI cycle still completes to DONE and the result is discarded.
- Reset values (asynchronous, also mid-access): state IDLE; otg_cs_n=1, otg_rd_n=1, otg_wr_n=1, otg_addr=0, otg_data_out=0, otg_data_oe=0, readdata=0, irq=0. The bus is released immediately.

Optional Feature:
- Macro: OTG_HPI_IRQ_EN.
- Defined:
  - Adds input otg_int (1) and output irq (1).
  - otg_int goes through a 2-flop synchronizer; irq is the synchronized level (reset 0), latency 2 cycles.
  - A STATUS read (address 3) additionally returns the synchronized INT level in readdata[16].
- Undefined: the ports are absent and readdata[31:16] is always 0.

Decomposition:
- Package otg_hpi_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, DONE, RECOVER);
  - HPI address constants HPI_DATA=2'd0, HPI_MAILBOX=2'd1, HPI_ADDRESS=2'd2, HPI_STATUS=2'd3;
  - the counter width constant, 4.
- Sub-module otg_hpi_int_sync (2-flop synchronizer) is instantiated only under OTG_HPI_IRQ_EN.

Test Plan:
1. Write with defaults, address 2, writedata 0x0000_1234:
   - otg_cs_n low from cycle 1 to cycle 5;
   - otg_wr_n low in cycles 2-4;
   - otg_data_out=0x1234 with oe=1 in cycles 1-5;
   - waitrequest low only in cycle 6.
2. Read, address 0, chip drives 0xBEEF during STROBE:
   - readdata=0x0000_BEEF when waitrequest falls;
   - otg_data_oe stays 0 throughout.
3. Back-to-back writes with RECOVER_CYC=2:
   - second CS_N falls no earlier than 3 cycles after the first DONE;
   - no strobe overlap.
4. reset_n asserted during STROBE of a write:
   - otg_wr_n=1, otg_cs_n=1, oe=0 asynchronously;
   - after release, the next read completes normally.
5. HOLD_CYC=0, SETUP_CYC=1, PULSE_CYC=1: total latency 3 cycles; strobe rises in the same cycle CS_N rises is forbidden, so check CS_N rises one cycle later (in DONE).
6. OTG_HPI_IRQ_EN defined, otg_int pulses high:
   - irq rises 2 cycles later;
   - STATUS read returns readdata[16]=1.
